// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, grant encoding and
// a helper for the line-offset width.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } arb_gnt_e;

  // Number of byte-offset bits inside one cache line.
  function automatic int unsigned line_off_bits(input int unsigned words,
                                                input int unsigned dw);
    return $clog2(words * dw / 8);
  endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Beat counter for one line burst: synchronous clear, increment on ack,
// saturates on the last beat so it never wraps inside a burst.
module mem_beat_counter #(
  parameter  int unsigned WORDS = 4,
  localparam int unsigned BW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [BW-1:0] beat_o,
  output logic          last_o
);

  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;

  // NOTE: the default assignment first means every path assigns beat_d, so no latch is inferred.
  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (inc_i && !last_o) begin
      beat_d = beat_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = (beat_q == BW'(WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line bursts onto a single word-wide memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is D-cache priority.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ic_req,
  input  logic [AW-1:0] ic_addr,
  output logic [DW-1:0] ic_rdata,
  output logic          ic_rvalid,
  output logic          ic_done,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [AW-1:0] dc_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic          dc_wready,
  output logic [DW-1:0] dc_rdata,
  output logic          dc_rvalid,
  output logic          dc_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int unsigned BW      = $clog2(WORDS);
  localparam int unsigned OFF_W   = line_off_bits(WORDS, DW);
  localparam int unsigned BYTE_SH = $clog2(DW / 8);
  localparam logic [AW-1:0] LINE_MASK = {AW{1'b1}} << OFF_W;

  arb_state_e    state_q;
  arb_gnt_e      gnt_q;
  arb_gnt_e      gnt_d;
  logic          we_q;
  logic [AW-1:0] base_q;
  logic          mem_req_q;
  logic          ic_done_q;
  logic          dc_done_q;

  logic [BW-1:0] beat;
  logic          last_beat;
  logic          any_req;
  logic          start;
  logic          beat_ack;

  assign any_req  = ic_req | dc_req;
  assign start    = (state_q == IDLE) && any_req;
  assign beat_ack = (state_q == BURST) && mem_ack;

  // gnt_q keeps the previous winner after a burst, so it doubles as the
  // last-grant memory for round-robin.
  always_comb begin
    gnt_d = gnt_q;
    if (dc_req && !ic_req) begin
      gnt_d = GNT_DC;
    end else if (ic_req && !dc_req) begin
      gnt_d = GNT_IC;
    end else if (ic_req && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_d = (gnt_q == GNT_IC) ? GNT_DC : GNT_IC;
`else
      gnt_d = GNT_DC;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_IC;
      we_q      <= 1'b0;
      base_q    <= '0;
      mem_req_q <= 1'b0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q     <= gnt_d;
            we_q      <= (gnt_d == GNT_DC) && dc_we;
            base_q    <= ((gnt_d == GNT_DC) ? dc_addr : ic_addr) & LINE_MASK;
            mem_req_q <= 1'b1;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (mem_ack && last_beat) begin
            mem_req_q <= 1'b0;
            ic_done_q <= (gnt_q == GNT_IC);
            dc_done_q <= (gnt_q == GNT_DC);
            state_q   <= DONE;
          end
        end
        DONE: begin
          ic_done_q <= 1'b0;
          dc_done_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          ic_done_q <= 1'b0;
          dc_done_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  mem_beat_counter #(
    .WORDS (WORDS)
  ) u_beat_counter (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr_i  (start),
    .inc_i  (beat_ack),
    .beat_o (beat),
    .last_o (last_beat)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q & we_q;
  assign mem_addr  = base_q + (AW'(beat) << BYTE_SH);
  assign mem_wdata = dc_wdata;

  // Read data is broadcast; only the granted side sees rvalid.
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;
  assign ic_rvalid = beat_ack && (gnt_q == GNT_IC) && !we_q;
  assign dc_rvalid = beat_ack && (gnt_q == GNT_DC) && !we_q;
  assign dc_wready = beat_ack && (gnt_q == GNT_DC) && we_q;

  assign ic_done   = ic_done_q;
  assign dc_done   = dc_done_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: drivers queue expected beats/dones,
// a negedge monitor pops and compares whenever the DUT strobes a beat or done.
module tb_cache_mem_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_wready;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  typedef struct {
    bit          is_done;
    bit          dc;
    bit          we;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors       = 0;
  int   miscompares   = 0;
  int   beats_seen    = 0;
  int   dones_seen    = 0;
  int   cyc           = 0;
  int   last_beat_cyc = -100;
  int   ack_mode      = 0;   // 0 none, 1 every cycle, 2 alternate, 3 always (spurious)
  bit   gate          = 1'b0;
  int   b0;

  cache_mem_arbiter #(
    .WORDS (4),
    .AW    (32),
    .DW    (32)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_rvalid (ic_rvalid),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_wready (dc_wready),
    .dc_rdata  (dc_rdata),
    .dc_rvalid (dc_rvalid),
    .dc_done   (dc_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {16'hD0D0, a[15:0]};
  endfunction

  function automatic logic [31:0] wr_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [2:0] exp_strobes(input exp_t e);
    if (e.we) return 3'b001;
    return e.dc ? 3'b010 : 3'b100;
  endfunction

  task automatic push_burst(input bit dc, input bit we, input logic [31:0] base,
                            input int n, input bit with_done);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.dc      = dc;
      e.we      = we;
      e.addr    = base + 32'(i * 4);
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.dc      = dc;
      e.we      = we;
      e.addr    = base;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_beats(input int target, input string name);
    int n = 0;
    while (beats_seen < target && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check(name, 64'(beats_seen >= target), 64'd1);
  endtask

  task automatic wait_dones(input int target, input string name);
    int n = 0;
    while (dones_seen < target && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check(name, 64'(dones_seen >= target), 64'd1);
  endtask

  // Memory model: drives ack per mode plus address-tagged read/write words.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    dc_wdata  = '0;
    forever begin
      @(posedge CLK);
      #1;
      gate = ~gate;
      case (ack_mode)
        1:       mem_ack = mem_req;
        2:       mem_ack = mem_req & gate;
        3:       mem_ack = 1'b1;
        default: mem_ack = 1'b0;
      endcase
      mem_rdata = rd_word(mem_addr);
      dc_wdata  = wr_word(mem_addr);
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (mem_req && mem_ack) begin
        beats_seen++;
        last_beat_cyc = cyc;
        check("beat_expected", 64'(exp_q.size() != 0 && !exp_q[0].is_done), 64'd1);
        if (exp_q.size() != 0 && !exp_q[0].is_done) begin
          mon_e = exp_q.pop_front();
          check("beat_addr", 64'(mem_addr), 64'(mon_e.addr));
          check("beat_we", 64'(mem_we), 64'(mon_e.we));
          check("beat_strobes", 64'({ic_rvalid, dc_rvalid, dc_wready}), 64'(exp_strobes(mon_e)));
          if (mon_e.we)
            check("beat_wdata", 64'(mem_wdata), 64'(wr_word(mon_e.addr)));
          else if (mon_e.dc)
            check("beat_dc_rdata", 64'(dc_rdata), 64'(rd_word(mon_e.addr)));
          else
            check("beat_ic_rdata", 64'(ic_rdata), 64'(rd_word(mon_e.addr)));
        end
      end else begin
        if ({ic_rvalid, dc_rvalid, dc_wready} != 3'b000)
          check("stray_strobe", 64'({ic_rvalid, dc_rvalid, dc_wready}), 64'd0);
        if (mem_req) begin
          check("stall_expected", 64'(exp_q.size() != 0 && !exp_q[0].is_done), 64'd1);
          if (exp_q.size() != 0 && !exp_q[0].is_done) begin
            check("stall_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            check("stall_we", 64'(mem_we), 64'(exp_q[0].we));
          end
        end
      end
      if (ic_done || dc_done) begin
        dones_seen++;
        check("done_expected", 64'(exp_q.size() != 0 && exp_q[0].is_done), 64'd1);
        if (exp_q.size() != 0 && exp_q[0].is_done) begin
          mon_e = exp_q.pop_front();
          check("done_who", 64'({ic_done, dc_done}), mon_e.dc ? 64'd1 : 64'd2);
          check("done_latency", 64'(cyc - last_beat_cyc), 64'd1);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    RST_N   = 1'b0;
    ic_req  = 1'b0;
    ic_addr = '0;
    dc_req  = 1'b0;
    dc_we   = 1'b0;
    dc_addr = '0;

    #3;
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_ic_rvalid", 64'(ic_rvalid), 64'd0);
    check("rst_dc_rvalid", 64'(dc_rvalid), 64'd0);
    check("rst_ic_done",   64'(ic_done),   64'd0);
    check("rst_dc_done",   64'(dc_done),   64'd0);
    check("rst_dc_wready", 64'(dc_wready), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("idle_after_rst", 64'(mem_req), 64'd0);

    // I-cache fill, unaligned line address, ack every cycle
    ack_mode = 1;
    push_burst(1'b0, 1'b0, 32'h100, 4, 1'b1);
    ic_addr = 32'h104;
    ic_req  = 1'b1;
    wait_dones(1, "timeout_ic_fill");
    ic_req = 1'b0;

    // Simultaneous requests held for two bursts
    push_burst(1'b1, 1'b0, 32'h400, 4, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    push_burst(1'b0, 1'b0, 32'h500, 4, 1'b1);
`else
    push_burst(1'b1, 1'b0, 32'h400, 4, 1'b1);
`endif
    dc_we   = 1'b0;
    dc_addr = 32'h404;
    ic_addr = 32'h500;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    wait_dones(3, "timeout_contend");
    ic_req = 1'b0;
    dc_req = 1'b0;

    // D-cache writeback, ack on alternate cycles
    ack_mode = 2;
    push_burst(1'b1, 1'b1, 32'h200, 4, 1'b1);
    dc_we   = 1'b1;
    dc_addr = 32'h200;
    dc_req  = 1'b1;
    wait_dones(4, "timeout_dc_wb");
    dc_req = 1'b0;
    dc_we  = 1'b0;

    // I-cache request dropped mid-burst
    ack_mode = 1;
    push_burst(1'b0, 1'b0, 32'h600, 4, 1'b1);
    ic_addr = 32'h608;
    ic_req  = 1'b1;
    b0 = beats_seen;
    wait_beats(b0 + 2, "timeout_drop_beats");
    ic_req = 1'b0;
    wait_dones(5, "timeout_drop_done");

    // Spurious ack while idle, then a fresh request must start at beat 0
    ack_mode = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      check("idle_spurious_ack", 64'(mem_req), 64'd0);
    end
    ack_mode = 1;
    push_burst(1'b1, 1'b0, 32'h700, 4, 1'b1);
    dc_addr = 32'h70C;
    dc_req  = 1'b1;
    wait_dones(6, "timeout_after_spurious");
    dc_req = 1'b0;

    // Reset in the middle of a burst
    push_burst(1'b0, 1'b0, 32'h300, 3, 1'b0);
    ic_addr = 32'h300;
    ic_req  = 1'b1;
    b0 = beats_seen;
    wait_beats(b0 + 3, "timeout_pre_reset");
    RST_N  = 1'b0;
    ic_req = 1'b0;
    #1;
    check("abort_mem_req",   64'(mem_req),   64'd0);
    check("abort_ic_rvalid", 64'(ic_rvalid), 64'd0);
    check("abort_ic_done",   64'(ic_done),   64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    push_burst(1'b0, 1'b0, 32'h300, 4, 1'b1);
    ic_req = 1'b1;
    wait_dones(7, "timeout_post_reset");
    ic_req = 1'b0;

    repeat (3) @(negedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
